// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU control blocks.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int REG_W_DEF = 4;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next count: increment unless already saturated.
    always_comb begin
        q_d = q_q;
        if (inc && (q_q != {WIDTH{1'b1}})) begin
            q_d = q_q + WIDTH'(1);
        end else begin
            q_d = q_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= {WIDTH{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: PC/stage enables, flushes, load-use bubbles,
// branch squash and HLT drain for the IF/ID/EX/MEM/WB pipe.
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memRd_EX,
    input  logic [REG_W-1:0] wrReg_EX,
    input  logic [REG_W-1:0] rdReg1_ID,
    input  logic [REG_W-1:0] rdReg2_ID,
    input  logic             use1_ID,
    input  logic             use2_ID,
    input  logic             hlt_ID,
    input  logic             brTaken_MEM,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             IF_ID_EN,
    output logic             ID_EX_EN,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             hlt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e     state_d, state_q;
    logic [1:0] hpos_d, hpos_q;
    logic       hlt_d, hlt_q;
    logic       lu_s;
    logic       stall_inc_s;
    logic       flush_inc_s;

    assign lu_s = memRd_EX && (wrReg_EX != {REG_W{1'b0}}) &&
                  ((use1_ID && (rdReg1_ID == wrReg_EX)) ||
                   (use2_ID && (rdReg2_ID == wrReg_EX)));

    // Next-state and Mealy enable/flush decode.
    always_comb begin
        state_d      = state_q;
        hpos_d       = hpos_q;
        hlt_d        = hlt_q;
        pc_en        = 1'b0;
        IF_ID_EN     = 1'b0;
        ID_EX_EN     = 1'b0;
        EX_MEM_EN    = 1'b0;
        MEM_WB_EN    = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        if (!rst_n) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        state_d = RUN;
                    end else if (brTaken_MEM) begin
                        {pc_en, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN} = 5'b11111;
                        {IF_ID_flush, ID_EX_flush, EX_MEM_flush}         = 3'b111;
                        flush_inc_s = 1'b1;
                    end else if (lu_s) begin
                        // Hold PC and IF/ID, inject one bubble into EX.
                        {ID_EX_EN, EX_MEM_EN, MEM_WB_EN} = 3'b111;
                        ID_EX_flush = 1'b1;
                        stall_inc_s = 1'b1;
                    end else begin
                        {pc_en, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN} = 5'b11111;
                        if (hlt_ID) begin
                            state_d = DRAIN;
                            hpos_d  = 2'd0;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_busy) begin
                        state_d = DRAIN;
                    end else if (brTaken_MEM && (hpos_q == 2'd0)) begin
                        // HLT sits behind a taken branch: squash it and resume.
                        {pc_en, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN} = 5'b11111;
                        {IF_ID_flush, ID_EX_flush, EX_MEM_flush}         = 3'b111;
                        flush_inc_s = 1'b1;
                        state_d     = RUN;
                        hpos_d      = 2'd0;
                    end else begin
                        {IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN} = 4'b1111;
                        IF_ID_flush = 1'b1;
                        hpos_d      = hpos_q + 2'd1;
                        if (hpos_q == 2'd1) begin
                            state_d = HALTED;
                            hlt_d   = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
                HALTED: begin
                    hlt_d = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    hpos_d  = 2'd0;
                    hlt_d   = 1'b0;
                end
            endcase
        end
    end

    // State, HLT position and halt flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            hpos_q  <= 2'd0;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hpos_q  <= hpos_d;
            hlt_q   <= hlt_d;
        end
    end

    assign hlt = hlt_q;

    sat_cnt #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .q     (stall_cnt)
    );

    sat_cnt #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_s),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        memRd_EX;
    logic [3:0]  wrReg_EX;
    logic [3:0]  rdReg1_ID;
    logic [3:0]  rdReg2_ID;
    logic        use1_ID;
    logic        use2_ID;
    logic        hlt_ID;
    logic        brTaken_MEM;
    logic        mem_busy;
    logic        pc_en;
    logic        IF_ID_EN;
    logic        ID_EX_EN;
    logic        EX_MEM_EN;
    logic        MEM_WB_EN;
    logic        IF_ID_flush;
    logic        ID_EX_flush;
    logic        EX_MEM_flush;
    logic        hlt;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [7:0]  ctl;

    int pass_cnt;
    int total_cnt;

    // {pc_en, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_flush, ID_EX_flush, EX_MEM_flush}
    localparam logic [7:0] C_ZERO  = 8'b00000_000;
    localparam logic [7:0] C_ADV   = 8'b11111_000;
    localparam logic [7:0] C_LU    = 8'b00111_010;
    localparam logic [7:0] C_FLUSH = 8'b11111_111;
    localparam logic [7:0] C_DRAIN = 8'b01111_100;

    assign ctl = {pc_en, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
                  IF_ID_flush, ID_EX_flush, EX_MEM_flush};

    pipe_ctrl #(.CNT_W(16), .REG_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memRd_EX     (memRd_EX),
        .wrReg_EX     (wrReg_EX),
        .rdReg1_ID    (rdReg1_ID),
        .rdReg2_ID    (rdReg2_ID),
        .use1_ID      (use1_ID),
        .use2_ID      (use2_ID),
        .hlt_ID       (hlt_ID),
        .brTaken_MEM  (brTaken_MEM),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .IF_ID_EN     (IF_ID_EN),
        .ID_EX_EN     (ID_EX_EN),
        .EX_MEM_EN    (EX_MEM_EN),
        .MEM_WB_EN    (MEM_WB_EN),
        .IF_ID_flush  (IF_ID_flush),
        .ID_EX_flush  (ID_EX_flush),
        .EX_MEM_flush (EX_MEM_flush),
        .hlt          (hlt),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        memRd_EX    = 1'b0;
        wrReg_EX    = 4'd0;
        rdReg1_ID   = 4'd0;
        rdReg2_ID   = 4'd0;
        use1_ID     = 1'b0;
        use2_ID     = 1'b0;
        hlt_ID      = 1'b0;
        brTaken_MEM = 1'b0;
        mem_busy    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        total_cnt++;
        if (ctl !== C_ZERO) $display("FAIL reset_ctl got=%b exp=%b", ctl, C_ZERO); else pass_cnt++;
        total_cnt++;
        if (hlt !== 1'b0) $display("FAIL reset_hlt got=%b exp=0", hlt); else pass_cnt++;
        total_cnt++;
        if ({stall_cnt, flush_cnt} !== 32'd0) $display("FAIL reset_cnt got=%h exp=0", {stall_cnt, flush_cnt}); else pass_cnt++;
        rst_n = 1'b1;
        settle();
        total_cnt++;
        if (ctl !== C_ADV) $display("FAIL reset_run got=%b exp=%b", ctl, C_ADV); else pass_cnt++;
    endtask

    task automatic test_load_use();
        memRd_EX = 1'b1; wrReg_EX = 4'd3; rdReg1_ID = 4'd3; use1_ID = 1'b1;
        settle();
        total_cnt++;
        if (ctl !== C_LU) $display("FAIL lu_r3_ctl got=%b exp=%b", ctl, C_LU); else pass_cnt++;
        tick();
        idle();
        settle();
        total_cnt++;
        if (stall_cnt !== 16'd1) $display("FAIL lu_r3_cnt got=%0d exp=1", stall_cnt); else pass_cnt++;
        total_cnt++;
        if (ctl !== C_ADV) $display("FAIL lu_after got=%b exp=%b", ctl, C_ADV); else pass_cnt++;
        // Match on R0 never stalls.
        memRd_EX = 1'b1; wrReg_EX = 4'd0; rdReg1_ID = 4'd0; use1_ID = 1'b1;
        settle();
        total_cnt++;
        if (ctl !== C_ADV) $display("FAIL lu_r0_ctl got=%b exp=%b", ctl, C_ADV); else pass_cnt++;
        // Source-2 match, but unused source.
        wrReg_EX = 4'd5; rdReg1_ID = 4'd1; rdReg2_ID = 4'd5; use1_ID = 1'b1; use2_ID = 1'b0;
        settle();
        total_cnt++;
        if (ctl !== C_ADV) $display("FAIL lu_unused_ctl got=%b exp=%b", ctl, C_ADV); else pass_cnt++;
        // Non-load producer does not stall.
        memRd_EX = 1'b0; use2_ID = 1'b1;
        settle();
        total_cnt++;
        if (ctl !== C_ADV) $display("FAIL lu_noload_ctl got=%b exp=%b", ctl, C_ADV); else pass_cnt++;
        memRd_EX = 1'b1;
        settle();
        total_cnt++;
        if (ctl !== C_LU) $display("FAIL lu_src2_ctl got=%b exp=%b", ctl, C_LU); else pass_cnt++;
        tick();
        idle();
        settle();
        total_cnt++;
        if (stall_cnt !== 16'd2) $display("FAIL lu_src2_cnt got=%0d exp=2", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_branch_over_lu();
        memRd_EX = 1'b1; wrReg_EX = 4'd7; rdReg1_ID = 4'd7; use1_ID = 1'b1;
        brTaken_MEM = 1'b1;
        settle();
        total_cnt++;
        if (ctl !== C_FLUSH) $display("FAIL br_lu_ctl got=%b exp=%b", ctl, C_FLUSH); else pass_cnt++;
        tick();
        idle();
        settle();
        total_cnt++;
        if (stall_cnt !== 16'd2) $display("FAIL br_lu_stall got=%0d exp=2", stall_cnt); else pass_cnt++;
        total_cnt++;
        if (flush_cnt !== 16'd1) $display("FAIL br_lu_flush got=%0d exp=1", flush_cnt); else pass_cnt++;
    endtask

    task automatic test_busy_branch();
        brTaken_MEM = 1'b1;
        mem_busy    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            total_cnt++;
            if (ctl !== C_ZERO) $display("FAIL busy_br_ctl%0d got=%b exp=%b", i, ctl, C_ZERO); else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (flush_cnt !== 16'd1) $display("FAIL busy_br_hold got=%0d exp=1", flush_cnt); else pass_cnt++;
        mem_busy = 1'b0;
        settle();
        total_cnt++;
        if (ctl !== C_FLUSH) $display("FAIL busy_br_release got=%b exp=%b", ctl, C_FLUSH); else pass_cnt++;
        tick();
        idle();
        settle();
        total_cnt++;
        if (flush_cnt !== 16'd2) $display("FAIL busy_br_cnt got=%0d exp=2", flush_cnt); else pass_cnt++;
    endtask

    task automatic test_halt();
        do_reset();
        hlt_ID = 1'b1;
        settle();
        total_cnt++;
        if (ctl !== C_ADV) $display("FAIL halt_id_ctl got=%b exp=%b", ctl, C_ADV); else pass_cnt++;
        tick();
        hlt_ID = 1'b0;
        settle();
        total_cnt++;
        if (ctl !== C_DRAIN) $display("FAIL halt_drain0 got=%b exp=%b", ctl, C_DRAIN); else pass_cnt++;
        tick();
        total_cnt++;
        if ({ctl, hlt} !== {C_DRAIN, 1'b0}) $display("FAIL halt_drain1 got=%b exp=%b", {ctl, hlt}, {C_DRAIN, 1'b0}); else pass_cnt++;
        tick();
        total_cnt++;
        if (hlt !== 1'b1) $display("FAIL halt_hlt got=%b exp=1", hlt); else pass_cnt++;
        // Halted: nothing moves regardless of inputs.
        memRd_EX = 1'b1; wrReg_EX = 4'd2; rdReg1_ID = 4'd2; use1_ID = 1'b1; brTaken_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            total_cnt++;
            if ({ctl, hlt} !== {C_ZERO, 1'b1}) $display("FAIL halted_hold%0d got=%b exp=%b", i, {ctl, hlt}, {C_ZERO, 1'b1}); else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({stall_cnt, flush_cnt} !== 32'd0) $display("FAIL halted_cnt got=%h exp=0", {stall_cnt, flush_cnt}); else pass_cnt++;
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        total_cnt++;
        if ({ctl, hlt} !== {C_ADV, 1'b0}) $display("FAIL halted_reset got=%b exp=%b", {ctl, hlt}, {C_ADV, 1'b0}); else pass_cnt++;
    endtask

    task automatic test_halt_wrong_path();
        do_reset();
        hlt_ID = 1'b1;
        tick();
        hlt_ID = 1'b0;
        brTaken_MEM = 1'b1;
        settle();
        total_cnt++;
        if (ctl !== C_FLUSH) $display("FAIL wp_flush got=%b exp=%b", ctl, C_FLUSH); else pass_cnt++;
        tick();
        brTaken_MEM = 1'b0;
        settle();
        total_cnt++;
        if ({ctl, hlt} !== {C_ADV, 1'b0}) $display("FAIL wp_resume got=%b exp=%b", {ctl, hlt}, {C_ADV, 1'b0}); else pass_cnt++;
        total_cnt++;
        if (flush_cnt !== 16'd1) $display("FAIL wp_cnt got=%0d exp=1", flush_cnt); else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if ({ctl, hlt} !== {C_ADV, 1'b0}) $display("FAIL wp_stay_run got=%b exp=%b", {ctl, hlt}, {C_ADV, 1'b0}); else pass_cnt++;
    endtask

    task automatic test_halt_busy();
        do_reset();
        hlt_ID = 1'b1;
        tick();
        hlt_ID = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            total_cnt++;
            if ({ctl, hlt} !== {C_ZERO, 1'b0}) $display("FAIL drain_busy%0d got=%b exp=%b", i, {ctl, hlt}, {C_ZERO, 1'b0}); else pass_cnt++;
            tick();
        end
        mem_busy = 1'b0;
        settle();
        total_cnt++;
        if (ctl !== C_DRAIN) $display("FAIL drain_busy_rel got=%b exp=%b", ctl, C_DRAIN); else pass_cnt++;
        tick();
        total_cnt++;
        if ({ctl, hlt} !== {C_DRAIN, 1'b0}) $display("FAIL drain_busy_pos1 got=%b exp=%b", {ctl, hlt}, {C_DRAIN, 1'b0}); else pass_cnt++;
        tick();
        total_cnt++;
        if ({ctl, hlt} !== {C_ZERO, 1'b1}) $display("FAIL drain_busy_hlt got=%b exp=%b", {ctl, hlt}, {C_ZERO, 1'b1}); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        memRd_EX = 1'b1; wrReg_EX = 4'd9; rdReg2_ID = 4'd9; use2_ID = 1'b1;
        for (int i = 0; i < 65539; i++) begin
            tick();
        end
        total_cnt++;
        if (stall_cnt !== 16'hFFFF) $display("FAIL sat_stall got=%h exp=ffff", stall_cnt); else pass_cnt++;
        total_cnt++;
        if (flush_cnt !== 16'd0) $display("FAIL sat_flush got=%h exp=0", flush_cnt); else pass_cnt++;
        idle();
        rst_n = 1'b0;
        tick();
        total_cnt++;
        if ({stall_cnt, flush_cnt, hlt} !== 33'd0) $display("FAIL sat_reset got=%h exp=0", {stall_cnt, flush_cnt, hlt}); else pass_cnt++;
        rst_n = 1'b1;
        settle();
        total_cnt++;
        if (ctl !== C_ADV) $display("FAIL sat_reset_run got=%b exp=%b", ctl, C_ADV); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_branch_over_lu();
        test_busy_branch();
        test_halt();
        test_halt_wrong_path();
        test_halt_busy();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage CPU (IF/ID/EX/MEM/WB). It generates the PC enable, the four inter-stage flop enables and the per-stage flush controls. It inserts load-use bubbles, squashes wrong-path instructions on a taken branch/jump resolved in MEM, freezes the pipe on memory busy, and drains the pipe on HLT before asserting `hlt`. Register-forwarding selection stays in the hazard unit; this block only decides stall, flush and advance.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `REG_W`, default 4: register-specifier width.

- `clk` input 1: clock.
- `rst_n` input 1: synchronous, active-low reset.
- `memRd_EX` input 1: instruction in EX is a load.
- `wrReg_EX` input REG_W: destination register of the instruction in EX.
- `rdReg1_ID`, `rdReg2_ID` input REG_W: source registers of the instruction in ID.
- `use1_ID`, `use2_ID` input 1: the ID instruction actually reads that source.
- `hlt_ID` input 1: the instruction in ID is HLT.
- `brTaken_MEM` input 1: branch/jump in MEM is taken (drives `useAlt` in IF).
- `mem_busy` input 1: data/instruction memory not ready this cycle.
- `pc_en` output 1: PC register update enable.
- `IF_ID_EN`, `ID_EX_EN`, `EX_MEM_EN`, `MEM_WB_EN` output 1: stage flop enables.
- `IF_ID_flush`, `ID_EX_flush`, `EX_MEM_flush` output 1: the stage flop loads a NOP (all controls zero) on this edge. Only meaningful when the matching EN is 1.
- `hlt` output 1: registered; the CPU is halted.
- `stall_cnt`, `flush_cnt` output CNT_W: saturating counts of load-use bubbles and branch flushes.

## Operation
- States: RUN, DRAIN, HALTED. A 2-bit `hpos` tracks the HLT position while in DRAIN (0 = EX, 1 = MEM).
- Priority each cycle, highest first: reset, HALTED, `mem_busy`, branch flush, load-use stall, normal advance.
- `mem_busy`=1: all EN=0, `pc_en`=0, all flushes 0. State, `hpos` and counters hold; the branch flush is deferred, since the frozen pipe holds `brTaken_MEM` stable.
- Branch flush (`brTaken_MEM`=1):
  - All EN=1, `pc_en`=1 (redirect), `IF_ID_flush`=`ID_EX_flush`=`EX_MEM_flush`=1.
  - `flush_cnt`++.
  - Overrides any load-use stall in the same cycle.
- Load-use (`lu`):
  - `lu` = `memRd_EX` & `wrReg_EX`≠0 & ((`use1_ID` & `rdReg1_ID`==`wrReg_EX`) | (`use2_ID` & `rdReg2_ID`==`wrReg_EX`)).
  - Response: `pc_en`=0, `IF_ID_EN`=0, `ID_EX_EN`=1 with `ID_EX_flush`=1, `EX_MEM_EN`=`MEM_WB_EN`=1.
  - `stall_cnt`++.
  - Exactly one bubble; forwarding covers the next cycle.
- Normal advance: `pc_en` and all EN=1, flushes 0.
- RUN→DRAIN: `hlt_ID`=1 and the HLT advances into EX (no busy, no flush, no `lu`). Set `hpos`=0.
- DRAIN:
  - `pc_en`=0 and `IF_ID_flush`=1 every cycle, so only bubbles follow the HLT. `lu` cannot occur.
  - `hpos` increments on each non-busy cycle.
  - `brTaken_MEM` with `hpos`=0: the HLT is on the wrong path. Do the normal flush, go to RUN, clear `hpos`.
  - Advance with `hpos`=1 (HLT entering WB): go to HALTED.
- HALTED: all EN=0, `pc_en`=0, flushes 0, `hlt`=1. The state is left only by reset.
- Counters saturate at all-ones and never wrap.

## Timing
- Enables and flushes are combinational (Mealy) from state and inputs. They are valid in the same cycle and sampled by the datapath flops on the next rising edge.
- `hlt` is registered and rises on the edge at which the HLT is loaded into MEM/WB, i.e. the same cycle the HLT sits in WB.
- Minimum HLT latency is 3 edges from the HLT in ID to `hlt`=1. Each `mem_busy` cycle adds 1.
- Reset (`rst_n`=0 sampled at an edge): state=RUN, `hpos`=0, `hlt`=0, counters=0. While `rst_n`=0, all EN=0, `pc_en`=0 and flushes=0.
- Reset mid-DRAIN or in HALTED returns to RUN on that edge.

## Structure
- Shared package `cpu_pkg`: state enum (RUN/DRAIN/HALTED) and the REG_W default constant.
- Sub-module `sat_cnt` (parameter width; inputs `clk`, `rst_n`, `inc`; output `q`), instantiated for `stall_cnt` and `flush_cnt`.
- Load-use compare stays inline.

## Test plan
- LW R3 in EX, ADD in ID reading R3 (`use1_ID`=1) → one cycle with `pc_en`=0, `IF_ID_EN`=0, `ID_EX_flush`=1; `stall_cnt`=1. A match on R0 → no stall.
- `brTaken_MEM`=1 while `lu`=1 → three flushes, `pc_en`=1, `stall_cnt` unchanged, `flush_cnt`=1.
- HLT in ID, no stalls → DRAIN with `IF_ID_flush`=1 for 2 cycles; `hlt`=1 after the 3rd edge; all EN stay 0 afterwards.
- HLT enters EX, then the next cycle `brTaken_MEM`=1 (`hpos`=0) → back to RUN, `hlt` stays 0, fetch resumes (`pc_en`=1).
- `mem_busy`=1 for 4 cycles during DRAIN and during a pending branch → all EN=0, `hpos` and counters frozen; the flush executes on the first non-busy cycle.
- Force 2^CNT_W+3 load-use stalls → `stall_cnt`=all-ones. Then `rst_n`=0 → counters=0, `hlt`=0, state=RUN.
